// File: rtl/lcb_frame_rx.sv
// LCB reply framing stage: writes received bytes into the channel buffer,
// enforces a fixed reply length and an inter-byte gap timeout, checks the
// trailing additive checksum and holds "full" until the reader releases it.
module lcb_frame_rx #(
    parameter int PKT_LEN   = 8,
    parameter int GAP_TICKS = 400,
    parameter int ADDR_W    = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rstTx,
    input  logic              strob,
    input  logic [7:0]        iData,
    input  logic              rstWr,
    output logic [ADDR_W-1:0] wrAdr,
    output logic [7:0]        wrData,
    output logic              WE,
    output logic              full,
    output logic              sumOk,
    output logic              errShort,
    output logic              ovr,
    output logic [ADDR_W-1:0] byteCnt
);

    // Timer holds "cycles since the last accepted byte"; it is reloaded with 1
    // so that errShort lands exactly GAP_TICKS cycles after the last strob.
    localparam int                TMR_W     = $clog2(GAP_TICKS + 1);
    localparam logic [TMR_W-1:0]  LAST_TICK = TMR_W'(GAP_TICKS - 1);
    localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(PKT_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        HOLD
    } state_t;

    state_t            state_q,     state_d;
    logic [ADDR_W-1:0] byte_cnt_q,  byte_cnt_d;
    logic [ADDR_W-1:0] wr_adr_q,    wr_adr_d;
    logic [7:0]        wr_data_q,   wr_data_d;
    logic [7:0]        sum_q,       sum_d;
    logic [TMR_W-1:0]  timer_q,     timer_d;
    logic              we_q,        we_d;
    logic              full_q,      full_d;
    logic              sum_ok_q,    sum_ok_d;
    logic              err_short_q, err_short_d;
    logic              ovr_q,       ovr_d;

    // Next-state and registered-output logic; rstTx overrides everything.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        wr_adr_d    = wr_adr_q;
        wr_data_d   = wr_data_q;
        sum_d       = sum_q;
        timer_d     = timer_q;
        full_d      = full_q;
        sum_ok_d    = sum_ok_q;
        we_d        = 1'b0;
        err_short_d = 1'b0;
        ovr_d       = 1'b0;

        if (rstTx) begin
            state_d    = IDLE;
            byte_cnt_d = '0;
            sum_d      = '0;
            timer_d    = '0;
            full_d     = 1'b0;
            sum_ok_d   = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (strob) begin
                        we_d       = 1'b1;
                        wr_adr_d   = '0;
                        wr_data_d  = iData;
                        byte_cnt_d = ADDR_W'(1);
                        sum_d      = iData;
                        timer_d    = TMR_W'(1);
                        state_d    = RECV;
                    end
                end

                RECV: begin
                    if (strob) begin
                        we_d       = 1'b1;
                        wr_adr_d   = byte_cnt_q;
                        wr_data_d  = iData;
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        timer_d    = TMR_W'(1);
                        if (byte_cnt_q == LAST_IDX) begin
                            full_d   = 1'b1;
                            sum_ok_d = (iData == sum_q);
                            state_d  = HOLD;
                        end else begin
                            sum_d = sum_q + iData;
                        end
                    end else if (timer_q >= LAST_TICK) begin
                        err_short_d = 1'b1;
                        byte_cnt_d  = '0;
                        sum_d       = '0;
                        timer_d     = '0;
                        state_d     = IDLE;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end

                HOLD: begin
                    ovr_d = strob;
                    if (rstWr) begin
                        full_d     = 1'b0;
                        sum_ok_d   = 1'b0;
                        byte_cnt_d = '0;
                        sum_d      = '0;
                        state_d    = IDLE;
                    end
                end

                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            wr_adr_q    <= '0;
            wr_data_q   <= '0;
            sum_q       <= '0;
            timer_q     <= '0;
            we_q        <= 1'b0;
            full_q      <= 1'b0;
            sum_ok_q    <= 1'b0;
            err_short_q <= 1'b0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            wr_adr_q    <= wr_adr_d;
            wr_data_q   <= wr_data_d;
            sum_q       <= sum_d;
            timer_q     <= timer_d;
            we_q        <= we_d;
            full_q      <= full_d;
            sum_ok_q    <= sum_ok_d;
            err_short_q <= err_short_d;
            ovr_q       <= ovr_d;
        end
    end

    assign wrAdr    = wr_adr_q;
    assign wrData   = wr_data_q;
    assign WE       = we_q;
    assign full     = full_q;
    assign sumOk    = sum_ok_q;
    assign errShort = err_short_q;
    assign ovr      = ovr_q;
    assign byteCnt  = byte_cnt_q;

endmodule
